// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite master: turns a single-command valid/ready stream into AXI4-Lite
// transactions, one outstanding at a time, with a sticky slave-timeout flag.
module axi_lite_cmd_master #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    axi_aclk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_write,
    output logic                    timeout,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam bit TO_EN  = (TIMEOUT_CYCLES > 0);
    localparam int CNT_W  = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_RESP,
        S_RD_REQ,
        S_RD_RESP,
        S_RESP
    } state_t;

    state_t                r_state;
    state_t                w_state_n;
    logic                  r_awvalid, w_awvalid_n;
    logic                  r_wvalid, w_wvalid_n;
    logic                  r_arvalid, w_arvalid_n;
    logic                  r_bready, w_bready_n;
    logic                  r_rready, w_rready_n;
    logic                  r_rsp_valid, w_rsp_valid_n;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]     r_wstrb;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_resp;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_timeout;
    logic                  w_accept;
    logic                  w_b_hs;
    logic                  w_r_hs;
    logic                  w_busy;

    assign w_accept = (r_state == S_IDLE) && cmd_valid;
    assign w_b_hs   = r_bready && m_axi_bvalid;
    assign w_r_hs   = r_rready && m_axi_rvalid;
    assign w_busy   = (r_state == S_WR_REQ) || (r_state == S_WR_RESP) ||
                      (r_state == S_RD_REQ) || (r_state == S_RD_RESP);

    always_ff @(posedge axi_aclk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_bready    <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_awvalid   <= w_awvalid_n;
            r_wvalid    <= w_wvalid_n;
            r_arvalid   <= w_arvalid_n;
            r_bready    <= w_bready_n;
            r_rready    <= w_rready_n;
            r_rsp_valid <= w_rsp_valid_n;
        end
    end

    // Next values of the registered handshake outputs; each valid only ever
    // depends on the current registers, never combinationally on a ready.
    always_comb begin
        w_state_n     = r_state;
        w_awvalid_n   = r_awvalid;
        w_wvalid_n    = r_wvalid;
        w_arvalid_n   = r_arvalid;
        w_bready_n    = r_bready;
        w_rready_n    = r_rready;
        w_rsp_valid_n = r_rsp_valid;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_write) begin
                        w_state_n   = S_WR_REQ;
                        w_awvalid_n = 1'b1;
                        w_wvalid_n  = 1'b1;
                    end else begin
                        w_state_n   = S_RD_REQ;
                        w_arvalid_n = 1'b1;
                    end
                end
            end
            S_WR_REQ: begin
                if (r_awvalid && m_axi_awready) w_awvalid_n = 1'b0;
                if (r_wvalid && m_axi_wready)   w_wvalid_n  = 1'b0;
                if (!w_awvalid_n && !w_wvalid_n) begin
                    w_state_n  = S_WR_RESP;
                    w_bready_n = 1'b1;
                end
            end
            S_WR_RESP: begin
                if (w_b_hs) begin
                    w_state_n     = S_RESP;
                    w_bready_n    = 1'b0;
                    w_rsp_valid_n = 1'b1;
                end
            end
            S_RD_REQ: begin
                if (r_arvalid && m_axi_arready) begin
                    w_state_n   = S_RD_RESP;
                    w_arvalid_n = 1'b0;
                    w_rready_n  = 1'b1;
                end
            end
            S_RD_RESP: begin
                if (w_r_hs) begin
                    w_state_n     = S_RESP;
                    w_rready_n    = 1'b0;
                    w_rsp_valid_n = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_n     = S_IDLE;
                    w_rsp_valid_n = 1'b0;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_write <= 1'b0;
            r_rdata <= '0;
            r_resp  <= 2'b00;
        end else begin
            if (w_accept) begin
                r_addr  <= cmd_addr;
                r_wdata <= cmd_wdata;
                r_wstrb <= cmd_wstrb;
                r_write <= cmd_write;
            end
            if (w_b_hs) begin
                r_resp  <= m_axi_bresp;
                r_rdata <= '0;
            end
            if (w_r_hs) begin
                r_resp  <= m_axi_rresp;
                r_rdata <= m_axi_rdata;
            end
        end
    end

    // Timeout only flags a slow slave; the transaction itself keeps going.
    always_ff @(posedge axi_aclk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else if (w_accept) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else if (TO_EN && w_busy && (r_cnt != TO_LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == TO_LIMIT - 1'b1) r_timeout <= 1'b1;
        end
    end

    assign cmd_ready     = (r_state == S_IDLE);
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rdata;
    assign rsp_resp      = r_resp;
    assign rsp_write     = r_write;
    assign timeout       = r_timeout;
    assign m_axi_awaddr  = r_addr;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign m_axi_araddr  = r_addr;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = r_arvalid;
    assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: directed commands against a delay-configurable
// AXI4-Lite slave model, with a response scoreboard and handshake-stability monitor.
module tb_axi_lite_cmd_master;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 16;
  localparam int EW = 35;

  logic axi_aclk = 1'b0;
  logic reset = 1'b1;
  always #5 axi_aclk = ~axi_aclk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_write;
  logic          timeout;
  logic [AW-1:0] m_axi_awaddr;
  logic [2:0]    m_axi_awprot;
  logic          m_axi_awvalid;
  logic          m_axi_awready = 1'b0;
  logic [DW-1:0] m_axi_wdata;
  logic [SW-1:0] m_axi_wstrb;
  logic          m_axi_wvalid;
  logic          m_axi_wready = 1'b0;
  logic [1:0]    m_axi_bresp = 2'b00;
  logic          m_axi_bvalid = 1'b0;
  logic          m_axi_bready;
  logic [AW-1:0] m_axi_araddr;
  logic [2:0]    m_axi_arprot;
  logic          m_axi_arvalid;
  logic          m_axi_arready = 1'b0;
  logic [DW-1:0] m_axi_rdata = '0;
  logic [1:0]    m_axi_rresp = 2'b00;
  logic          m_axi_rvalid = 1'b0;
  logic          m_axi_rready;

  axi_lite_cmd_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .axi_aclk(axi_aclk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_write(rsp_write), .timeout(timeout),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  int rsp_cnt = 0;
  int rsp_target = 0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  logic [AW-1:0] last_araddr = '0;
  logic [AW-1:0] last_awaddr = '0;
  logic [DW-1:0] last_wdata = '0;

  // slave model configuration
  int aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0]    cfg_bresp = 2'b00;
  logic [1:0]    cfg_rresp = 2'b00;
  logic [DW-1:0] cfg_rdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- monitor: fires, responses, stability ----------------
  bit aw_seen = 0, w_seen = 0, ar_seen = 0, b_seen = 0, r_seen = 0;
  bit p_aw = 0, p_w = 0, p_ar = 0, p_rsp = 0;
  logic [AW:0]      p_aw_v;
  logic [DW+SW:0]   p_w_v;
  logic [AW:0]      p_ar_v;
  logic [EW:0]      p_rsp_v;

  always @(negedge axi_aclk) begin
    if (reset) begin
      p_aw = 0; p_w = 0; p_ar = 0; p_rsp = 0;
    end else begin
      if (p_aw)  chk("awvalid_hold", {m_axi_awvalid, m_axi_awaddr}, p_aw_v);
      if (p_w)   chk("wvalid_hold", {m_axi_wvalid, m_axi_wstrb, m_axi_wdata}, p_w_v);
      if (p_ar)  chk("arvalid_hold", {m_axi_arvalid, m_axi_araddr}, p_ar_v);
      if (p_rsp) chk("rsp_hold", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, p_rsp_v);
      p_aw = m_axi_awvalid && !m_axi_awready;
      p_aw_v = {1'b1, m_axi_awaddr};
      p_w = m_axi_wvalid && !m_axi_wready;
      p_w_v = {1'b1, m_axi_wstrb, m_axi_wdata};
      p_ar = m_axi_arvalid && !m_axi_arready;
      p_ar_v = {1'b1, m_axi_araddr};
      p_rsp = rsp_valid && !rsp_ready;
      p_rsp_v = {1'b1, rsp_write, rsp_resp, rsp_rdata};

      if (m_axi_awvalid && m_axi_awready) begin aw_cnt++; aw_seen = 1; last_awaddr = m_axi_awaddr; end
      if (m_axi_wvalid && m_axi_wready) begin w_cnt++; w_seen = 1; last_wdata = m_axi_wdata; end
      if (m_axi_arvalid && m_axi_arready) begin ar_cnt++; ar_seen = 1; last_araddr = m_axi_araddr; end
      if (m_axi_bvalid && m_axi_bready) b_seen = 1;
      if (m_axi_rvalid && m_axi_rready) r_seen = 1;

      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_payload", {rsp_write, rsp_resp, rsp_rdata}, mon_e);
        end
      end
    end
  end

  // ---------------- slave model (drives at posedge+2) ----------------
  bit got_aw = 0, got_w = 0, got_ar = 0;
  int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;

  initial begin
    forever begin
      @(posedge axi_aclk);
      #2;
      if (reset) begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_rvalid = 0;
        got_aw = 0; got_w = 0; got_ar = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        aw_seen = 0; w_seen = 0; ar_seen = 0; b_seen = 0; r_seen = 0;
      end else begin
        if (b_seen) begin m_axi_bvalid = 0; b_seen = 0; end
        if (r_seen) begin m_axi_rvalid = 0; r_seen = 0; end
        if (aw_seen) begin got_aw = 1; aw_seen = 0; end
        if (w_seen) begin got_w = 1; w_seen = 0; end
        if (ar_seen) begin got_ar = 1; ar_seen = 0; end
        if (m_axi_awvalid) begin m_axi_awready = (aw_wait >= aw_delay); aw_wait++; end
        else begin m_axi_awready = 0; aw_wait = 0; end
        if (m_axi_wvalid) begin m_axi_wready = (w_wait >= w_delay); w_wait++; end
        else begin m_axi_wready = 0; w_wait = 0; end
        if (m_axi_arvalid) begin m_axi_arready = (ar_wait >= ar_delay); ar_wait++; end
        else begin m_axi_arready = 0; ar_wait = 0; end
        if (got_aw && got_w && !m_axi_bvalid) begin
          if (b_wait >= b_delay) begin
            m_axi_bvalid = 1; m_axi_bresp = cfg_bresp;
            got_aw = 0; got_w = 0; b_wait = 0;
          end else b_wait++;
        end
        if (got_ar && !m_axi_rvalid) begin
          if (r_wait >= r_delay) begin
            m_axi_rvalid = 1; m_axi_rdata = cfg_rdata; m_axi_rresp = cfg_rresp;
            got_ar = 0; r_wait = 0;
          end else r_wait++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge axi_aclk);
    #2;
  endtask

  // Called at posedge+2; returns at posedge+2 of the first cycle after accept.
  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, input bit push, input logic [EW-1:0] e);
    int n;
    n = 0;
    if (push) begin exp_q.push_back(e); rsp_target++; end
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(negedge axi_aclk);
    while (!cmd_ready && n < 200) begin @(negedge axi_aclk); n++; end
    chk("cmd_accept", cmd_ready, 1);
    tick();
    cmd_valid = 0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (rsp_cnt < rsp_target && n < 500) begin @(negedge axi_aclk); n++; end
    chk("rsp_arrived", rsp_cnt >= rsp_target, 1);
    tick();
  endtask

  // ---------------- directed tests ----------------
  int aw0, w0, ar0, stale;

  initial begin
    // reset state, both during and after reset
    repeat (3) @(negedge axi_aclk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, rsp_valid}, 0);
    chk("rst_readies", {m_axi_bready, m_axi_rready}, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_data", {rsp_rdata, rsp_resp, rsp_write, m_axi_awaddr, m_axi_wdata}, 0);
    tick();
    reset = 0;
    @(negedge axi_aclk);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, rsp_valid}, 0);
    chk("prot", {m_axi_awprot, m_axi_arprot}, 0);
    tick();

    // zero-wait write
    aw0 = aw_cnt; w0 = w_cnt;
    send_cmd(1, 4'h4, 32'hDEADBEEF, 4'hF, 1, {1'b1, 2'b00, 32'h0});
    @(negedge axi_aclk);
    chk("t1_aw_w_valid", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
    chk("t1_awaddr", m_axi_awaddr, 4'h4);
    chk("t1_wdata", m_axi_wdata, 32'hDEADBEEF);
    chk("t1_wstrb", m_axi_wstrb, 4'hF);
    @(negedge axi_aclk);
    chk("t1_c2_valids", {m_axi_awvalid, m_axi_wvalid, rsp_valid}, 0);
    chk("t1_bready", m_axi_bready, 1);
    @(negedge axi_aclk);
    chk("t1_rsp_latency", rsp_valid, 1);
    wait_rsp();
    chk("t1_aw_count", aw_cnt - aw0, 1);
    chk("t1_w_count", w_cnt - w0, 1);
    chk("t1_slave_addr", last_awaddr, 4'h4);

    // AW accepted three cycles before W
    w_delay = 3;
    aw0 = aw_cnt; w0 = w_cnt;
    send_cmd(1, 4'hC, 32'h0000_1234, 4'h3, 1, {1'b1, 2'b00, 32'h0});
    @(negedge axi_aclk);
    chk("t2_c1_valids", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
    @(negedge axi_aclk);
    chk("t2_c2_valids", {m_axi_awvalid, m_axi_wvalid}, 2'b01);
    wait_rsp();
    chk("t2_aw_count", aw_cnt - aw0, 1);
    chk("t2_w_count", w_cnt - w0, 1);
    chk("t2_slave_wdata", last_wdata, 32'h0000_1234);
    w_delay = 0;

    // read with delayed arready and rvalid
    ar_delay = 2; r_delay = 5; cfg_rdata = 32'h0000_00A5; cfg_rresp = 2'b00;
    ar0 = ar_cnt;
    send_cmd(0, 4'h8, 32'h0, 4'h0, 1, {1'b0, 2'b00, 32'h0000_00A5});
    @(negedge axi_aclk);
    chk("t3_arvalid", m_axi_arvalid, 1);
    chk("t3_araddr", m_axi_araddr, 4'h8);
    wait_rsp();
    chk("t3_ar_count", ar_cnt - ar0, 1);
    chk("t3_slave_araddr", last_araddr, 4'h8);
    ar_delay = 0; r_delay = 0;

    // response back-pressure with SLVERR, next command waiting
    cfg_rdata = 32'h1234_5678; cfg_rresp = 2'b10;
    rsp_ready = 0;
    send_cmd(0, 4'h0, 32'h0, 4'h0, 1, {1'b0, 2'b10, 32'h1234_5678});
    stale = 0;
    while (!rsp_valid && stale < 50) begin @(negedge axi_aclk); stale++; end
    chk("t4_rsp_valid_seen", rsp_valid, 1);
    tick();
    exp_q.push_back({1'b1, 2'b00, 32'h0}); rsp_target++;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 4'h4; cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'h5;
    repeat (10) begin
      @(negedge axi_aclk);
      chk("t4_cmd_ready_low", cmd_ready, 0);
      chk("t4_rsp_valid_held", rsp_valid, 1);
    end
    tick();
    rsp_ready = 1;
    @(negedge axi_aclk);
    tick();
    @(negedge axi_aclk);
    chk("t4_next_accept", cmd_ready, 1);
    tick();
    cmd_valid = 0;
    @(negedge axi_aclk);
    chk("t4_next_awvalid", m_axi_awvalid, 1);
    chk("t4_next_wdata", m_axi_wdata, 32'hCAFEF00D);
    wait_rsp();

    // timeout: bvalid withheld for 20 cycles, DECERR passed through
    b_delay = 20; cfg_bresp = 2'b11;
    send_cmd(1, 4'h0, 32'h1, 4'h1, 1, {1'b1, 2'b11, 32'h0});
    repeat (16) @(negedge axi_aclk);
    chk("t5_timeout_c16", timeout, 0);
    @(negedge axi_aclk);
    chk("t5_timeout_c17", timeout, 1);
    wait_rsp();
    @(negedge axi_aclk);
    chk("t5_timeout_sticky", timeout, 1);
    tick();
    b_delay = 0; cfg_bresp = 2'b00;
    cfg_rdata = 32'h55AA_0001; cfg_rresp = 2'b00;
    send_cmd(0, 4'h2, 32'h0, 4'h0, 1, {1'b0, 2'b00, 32'h55AA_0001});
    @(negedge axi_aclk);
    chk("t5_timeout_cleared", timeout, 0);
    wait_rsp();

    // reset while arvalid is high: command discarded, no response
    ar_delay = 10;
    send_cmd(0, 4'h6, 32'h0, 4'h0, 0, '0);
    @(negedge axi_aclk);
    chk("t6_arvalid_before", m_axi_arvalid, 1);
    #1 reset = 1;
    #1;
    chk("t6_arvalid_async", m_axi_arvalid, 0);
    chk("t6_rsp_valid_async", rsp_valid, 0);
    chk("t6_cmd_ready_async", cmd_ready, 1);
    repeat (3) tick();
    reset = 0;
    ar_delay = 0;
    stale = 0;
    repeat (12) begin
      @(negedge axi_aclk);
      if (rsp_valid || m_axi_arvalid) stale++;
    end
    chk("t6_no_stale", stale, 0);
    chk("t6_cmd_ready", cmd_ready, 1);
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", n_checks);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/axi_lite_cmd_master.md
Name: axi_lite_cmd_master

Overview:
Synthesizable AXI4-Lite master that sits directly upstream of the team's AXI4-Lite slave peripherals (PWM/IRQ IP, s00_axi and s_axi_intr ports). It converts a simple valid/ready command stream (single write or read) into AXI4-Lite channel handshakes and returns one response per command. It also flags slaves that do not answer within a programmable number of cycles. Only one transaction is outstanding at a time.

Parameters:
ADDR_WIDTH, 4, AXI address width, matching the slave's s_axi_awaddr/araddr width
DATA_WIDTH, 32, AXI data width; only 32 is supported
TIMEOUT_CYCLES, 1024, cycles without completion before timeout is set; 0 disables timeout

Ports:
axi_aclk  in  1  clock; all logic is on the rising edge
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  byte address
cmd_wdata  in  DATA_WIDTH  write data
cmd_wstrb  in  DATA_WIDTH/8  write strobes
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
rsp_resp  out  2  BRESP or RRESP value
rsp_write  out  1  echo of cmd_write for this response
timeout  out  1  sticky timeout flag
m_axi_awaddr  out  ADDR_WIDTH  write address
m_axi_awprot  out  3  constant 3'b000
m_axi_awvalid  out  1  write address valid
m_axi_awready  in  1  write address ready
m_axi_wdata  out  DATA_WIDTH  write data
m_axi_wstrb  out  DATA_WIDTH/8  write strobes
m_axi_wvalid  out  1  write data valid
m_axi_wready  in  1  write data ready
m_axi_bresp  in  2  write response
m_axi_bvalid  in  1  write response valid
m_axi_bready  out  1  write response ready
m_axi_araddr  out  ADDR_WIDTH  read address
m_axi_arprot  out  3  constant 3'b000
m_axi_arvalid  out  1  read address valid
m_axi_arready  in  1  read address ready
m_axi_rdata  in  DATA_WIDTH  read data
m_axi_rresp  in  2  read response
m_axi_rvalid  in  1  read data valid
m_axi_rready  out  1  read data ready

Behaviour:
- Reset (async assert, sync release): state IDLE; cmd_ready=1; all *valid, bready, rready, rsp_valid, timeout = 0; all data/address/resp outputs = 0.
- States are IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESP.
- IDLE: cmd_ready=1. On a command handshake, capture addr/wdata/wstrb/write into registers and clear timeout and the timeout counter.
  - Write → WR_REQ, with awvalid=1 and wvalid=1 on the next cycle.
  - Read → RD_REQ, with arvalid=1 on the next cycle.
  - cmd_ready=0 in all other states.
- WR_REQ: awvalid and wvalid are independent.
  - Each drops the cycle after its own handshake and never deasserts before it.
  - Address and data handshakes may complete in the same cycle or in either order.
  - When both are done → WR_RESP.
- WR_RESP: bready=1. On bvalid, capture bresp, set rsp_rdata=0, → RESP.
- RD_REQ: arvalid=1 until arready. Then → RD_RESP.
- RD_RESP: rready=1. On rvalid, capture rdata and rresp, → RESP.
- RESP: rsp_valid=1, with payload stable until rsp_ready. On handshake → IDLE.
  - Minimum command-to-response latency with a zero-wait slave: accept cycle, plus 1 request cycle, plus 1 response cycle; rsp_valid is high 3 cycles after the accept edge.
- AXI outputs are registered. Valid signals never depend combinationally on ready signals.
- Timeout:
  - The counter increments every cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
  - When the counter reaches TIMEOUT_CYCLES, timeout is set to 1 and the counter saturates.
  - The transaction is not aborted: AXI handshakes continue and complete normally.
  - timeout stays set until the next command is accepted or reset.
  - Counter width is clog2(TIMEOUT_CYCLES+1).
- A non-zero bresp/rresp (SLVERR/DECERR) is passed through unchanged. There is no retry.
- Reset mid-transaction: all valids drop asynchronously and the in-flight command is discarded with no response.

Test Plan:
- Zero-wait slave, write addr=0x4, wdata=0xDEADBEEF, wstrb=0xF → awvalid and wvalid high one cycle with the same values; bready seen; rsp_valid 3 cycles after accept with rsp_resp=0, rsp_rdata=0, rsp_write=1.
- Slave asserts awready 3 cycles before wready → awvalid drops after its handshake while wvalid holds; exactly one AW and one W handshake; one response.
- Read addr=0x8, slave returns rdata=0x0000_00A5 after 5 wait cycles on rvalid → rsp_rdata=0xA5, rsp_resp=0, arvalid held until arready.
- rsp_ready held low 10 cycles → rsp_valid and payload stable; cmd_ready=0 throughout; next command accepted the cycle after the response handshake.
- TIMEOUT_CYCLES=16, slave withholds bvalid 20 cycles → timeout=1 at cycle 16 of waiting; response still delivered on bvalid; timeout cleared on next accepted command.
- Reset asserted while arvalid=1 → arvalid, rsp_valid=0 immediately (asynchronously); after release cmd_ready=1 and no stale response appears.
